// File: rtl/cavlc_pkg.sv
// Shared parameters, FSM encoding and level helpers for the CAVLC coefficient scanner
// and its level/run store.
package cavlc_pkg;
    localparam int WIDTH     = 9;
    localparam int addrWIDTH = 4;
    localparam int DEPTH     = 16;
    localparam int TC_W      = 5;
    localparam int RUN_W     = 4;
    localparam logic [1:0] MAX_T1 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_REPORT = 3'd3,
        ST_EMIT   = 3'd4
    } scan_state_e;

    // Exact match on the raw two's-complement word so -256 never aliases to +/-1.
    function automatic logic is_unit_level(input logic [WIDTH-1:0] v);
        return (v == 9'h001) || (v == 9'h1FF);
    endfunction
endpackage

// File: rtl/level_run_store.sv
// DEPTH-entry {level, run, t1flag} register file: level/t1 and run columns have
// independent write ports, one combinational read port.
module level_run_store
    import cavlc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    lvl_we_i,
    input  logic [addrWIDTH-1:0]    lvl_waddr_i,
    input  logic signed [WIDTH-1:0] lvl_wdata_i,
    input  logic                    t1_wdata_i,
    input  logic                    run_we_i,
    input  logic [addrWIDTH-1:0]    run_waddr_i,
    input  logic [RUN_W-1:0]        run_wdata_i,
    input  logic [addrWIDTH-1:0]    raddr_i,
    output logic signed [WIDTH-1:0] level_o,
    output logic [RUN_W-1:0]        run_o,
    output logic                    t1_o
);
    logic signed [WIDTH-1:0] level_q [DEPTH];
    logic [RUN_W-1:0]        run_q   [DEPTH];
    logic [DEPTH-1:0]        t1flag_q;

    // Storage update; the run column trails the level column by one entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                level_q[i] <= 9'sd0;
                run_q[i]   <= 4'd0;
            end
            t1flag_q <= 16'd0;
        end else begin
            if (lvl_we_i) begin
                level_q[lvl_waddr_i]  <= lvl_wdata_i;
                t1flag_q[lvl_waddr_i] <= t1_wdata_i;
            end
            if (run_we_i) begin
                run_q[run_waddr_i] <= run_wdata_i;
            end
        end
    end

    assign level_o = level_q[raddr_i];
    assign run_o   = run_q[raddr_i];
    assign t1_o    = t1flag_q[raddr_i];
endmodule

// File: rtl/cavlc_coeff_scanner.sv
// Scans a zigzag block from index 15 down to 0, derives TotalCoeff/TrailingOnes/TotalZeros,
// then streams the stored levels with their run_before over a valid/ready port.
module cavlc_coeff_scanner
    import cavlc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    rd_en,
    output logic [addrWIDTH-1:0]    rd_addr,
    input  logic signed [WIDTH-1:0] rd_data,
    output logic                    stats_valid,
    output logic [TC_W-1:0]         total_coeff,
    output logic [1:0]              trailing_ones,
    output logic [3:0]              total_zeros,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic signed [WIDTH-1:0] sym_level,
    output logic [RUN_W-1:0]        sym_run,
    output logic                    sym_t1,
    output logic                    sym_last
);
    scan_state_e             state_q;
    logic                    busy_q, rd_en_q, data_vld_q, stats_valid_q;
    logic [addrWIDTH-1:0]    rd_addr_q, k_q;
    logic [TC_W-1:0]         tc_q, tc_d, total_coeff_q;
    logic [1:0]              t1_q, t1_d, trailing_ones_q;
    logic [3:0]              tz_q, tz_d, total_zeros_q;
    logic [RUN_W-1:0]        zrun_q, zrun_d;
    logic                    t1_active_q, t1_active_d;
    logic                    sym_valid_q, sym_t1_q, sym_last_q;
    logic signed [WIDTH-1:0] sym_level_q;
    logic [RUN_W-1:0]        sym_run_q;

    logic                    lvl_we_s, t1_wdata_s, run_we_s, st_t1_s;
    logic [addrWIDTH-1:0]    lvl_waddr_s, run_waddr_s, st_raddr_s;
    logic signed [WIDTH-1:0] lvl_wdata_s, st_level_s;
    logic [RUN_W-1:0]        run_wdata_s, st_run_s;
    logic [TC_W-1:0]         tc_m1_s;

    assign tc_m1_s = tc_q - 5'd1;

    // Per-coefficient statistics update and store writes for the word returned by the BRAM.
    always_comb begin
        tc_d        = tc_q;
        t1_d        = t1_q;
        tz_d        = tz_q;
        zrun_d      = zrun_q;
        t1_active_d = t1_active_q;
        lvl_we_s    = 1'b0;
        lvl_waddr_s = tc_q[addrWIDTH-1:0];
        lvl_wdata_s = rd_data;
        t1_wdata_s  = 1'b0;
        run_we_s    = 1'b0;
        run_waddr_s = tc_m1_s[addrWIDTH-1:0];
        run_wdata_s = zrun_q;
        if (data_vld_q) begin
            if (rd_data != 9'sd0) begin
                lvl_we_s = 1'b1;
                run_we_s = (tc_q != 5'd0);
                zrun_d   = 4'd0;
                tc_d     = tc_q + 5'd1;
                if (t1_active_q && is_unit_level(rd_data) && (t1_q < MAX_T1)) begin
                    t1_d       = t1_q + 2'd1;
                    t1_wdata_s = 1'b1;
                end else begin
                    t1_active_d = 1'b0;
                end
            end else if (tc_q != 5'd0) begin
                zrun_d = zrun_q + 4'd1;
                tz_d   = tz_q + 4'd1;
            end else begin
                zrun_d = zrun_q;
            end
        end else if (state_q == ST_REPORT) begin
            // Zeros below the lowest nonzero become the run of the final level.
            run_we_s = (tc_q != 5'd0);
        end else begin
            run_we_s = 1'b0;
        end
    end

    // Look one symbol ahead so the sym_* outputs can be loaded as registers.
    always_comb begin
        if (state_q == ST_EMIT) begin
            st_raddr_s = k_q + 4'd1;
        end else begin
            st_raddr_s = 4'd0;
        end
    end

    level_run_store u_store (
        .clk         (clk),
        .rst_n       (rst),
        .lvl_we_i    (lvl_we_s),
        .lvl_waddr_i (lvl_waddr_s),
        .lvl_wdata_i (lvl_wdata_s),
        .t1_wdata_i  (t1_wdata_s),
        .run_we_i    (run_we_s),
        .run_waddr_i (run_waddr_s),
        .run_wdata_i (run_wdata_s),
        .raddr_i     (st_raddr_s),
        .level_o     (st_level_s),
        .run_o       (st_run_s),
        .t1_o        (st_t1_s)
    );

    // Scan/report/emit sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            busy_q          <= 1'b0;
            rd_en_q         <= 1'b0;
            rd_addr_q       <= 4'd0;
            data_vld_q      <= 1'b0;
            tc_q            <= 5'd0;
            t1_q            <= 2'd0;
            tz_q            <= 4'd0;
            zrun_q          <= 4'd0;
            t1_active_q     <= 1'b0;
            stats_valid_q   <= 1'b0;
            total_coeff_q   <= 5'd0;
            trailing_ones_q <= 2'd0;
            total_zeros_q   <= 4'd0;
            k_q             <= 4'd0;
            sym_valid_q     <= 1'b0;
            sym_level_q     <= 9'sd0;
            sym_run_q       <= 4'd0;
            sym_t1_q        <= 1'b0;
            sym_last_q      <= 1'b0;
        end else begin
            tc_q          <= tc_d;
            t1_q          <= t1_d;
            tz_q          <= tz_d;
            zrun_q        <= zrun_d;
            t1_active_q   <= t1_active_d;
            data_vld_q    <= rd_en_q;
            stats_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_READ;
                        busy_q      <= 1'b1;
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= 4'd15;
                        tc_q        <= 5'd0;
                        t1_q        <= 2'd0;
                        tz_q        <= 4'd0;
                        zrun_q      <= 4'd0;
                        t1_active_q <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (rd_addr_q == 4'd0) begin
                        state_q <= ST_DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        rd_addr_q <= rd_addr_q - 4'd1;
                    end
                end
                ST_DRAIN: begin
                    state_q         <= ST_REPORT;
                    stats_valid_q   <= 1'b1;
                    total_coeff_q   <= tc_d;
                    trailing_ones_q <= t1_d;
                    total_zeros_q   <= tz_d;
                end
                ST_REPORT: begin
                    if (tc_q == 5'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q     <= ST_EMIT;
                        k_q         <= 4'd0;
                        sym_valid_q <= 1'b1;
                        sym_level_q <= st_level_s;
                        // Entry 0's run is written this same cycle when it is the only level.
                        sym_run_q   <= (tc_q == 5'd1) ? zrun_q : st_run_s;
                        sym_t1_q    <= st_t1_s;
                        sym_last_q  <= (tc_q == 5'd1);
                    end
                end
                ST_EMIT: begin
                    if (sym_ready) begin
                        if (sym_last_q) begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            sym_valid_q <= 1'b0;
                            sym_level_q <= 9'sd0;
                            sym_run_q   <= 4'd0;
                            sym_t1_q    <= 1'b0;
                            sym_last_q  <= 1'b0;
                        end else begin
                            k_q         <= k_q + 4'd1;
                            sym_level_q <= st_level_s;
                            sym_run_q   <= st_run_s;
                            sym_t1_q    <= st_t1_s;
                            sym_last_q  <= (({1'b0, k_q} + 5'd2) == tc_q);
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    rd_en_q     <= 1'b0;
                    sym_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign rd_en         = rd_en_q;
    assign rd_addr       = rd_addr_q;
    assign stats_valid   = stats_valid_q;
    assign total_coeff   = total_coeff_q;
    assign trailing_ones = trailing_ones_q;
    assign total_zeros   = total_zeros_q;
    assign sym_valid     = sym_valid_q;
    assign sym_level     = sym_level_q;
    assign sym_run       = sym_run_q;
    assign sym_t1        = sym_t1_q;
    assign sym_last      = sym_last_q;
endmodule

// File: tb/tb_cavlc_coeff_scanner.sv
// Self-checking bench for cavlc_coeff_scanner: table of blocks with expected stats,
// symbol scoreboard fed by a position-based reference model, plus backpressure and reset sequences.
module tb_cavlc_coeff_scanner;
    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, rd_en, stats_valid, sym_valid, sym_ready, sym_t1, sym_last;
    logic [3:0]        rd_addr, total_zeros, sym_run;
    logic signed [8:0] rd_data = 9'sd0;
    logic [4:0]        total_coeff;
    logic [1:0]        trailing_ones;
    logic signed [8:0] sym_level;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [8:0] level;
        logic [3:0] run;
        logic       t1;
        logic       last;
    } sym_t;

    typedef struct {
        logic [15:0][8:0] coef;
        int tc;
        int t1;
        int tz;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    sym_t sbq [$];
    logic [8:0] mem [16];

    cavlc_coeff_scanner dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .stats_valid   (stats_valid),
        .total_coeff   (total_coeff),
        .trailing_ones (trailing_ones),
        .total_zeros   (total_zeros),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .sym_level     (sym_level),
        .sym_run       (sym_run),
        .sym_t1        (sym_t1),
        .sym_last      (sym_last)
    );

    always #5 clk = ~clk;

    // Zigzag BRAM read port: one cycle of latency.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Scoreboard: every accepted symbol must match the next expected one.
    always @(negedge clk) begin
        sym_t got, exp;
        if (rst && sym_valid && sym_ready) begin
            got = {sym_level, sym_run, sym_t1, sym_last};
            n_checks++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL sym_unexpected: got level=%0d run=%0d t1=%0b last=%0b, want no symbol",
                         sym_level, sym_run, sym_t1, sym_last);
            end else begin
                exp = sbq.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL sym: got level=%0d run=%0d t1=%0b last=%0b, want level=%0d run=%0d t1=%0b last=%0b",
                             sym_level, sym_run, sym_t1, sym_last,
                             $signed(exp.level), exp.run, exp.t1, exp.last);
                end
            end
        end
    end

    // Reference model from nonzero positions: levels from highest index down.
    function automatic void model_block(input logic [15:0][8:0] c, input bit push,
                                        output int m_tc, output int m_t1, output int m_tz);
        int   pos [$];
        sym_t s;
        bit   t1_run;
        for (int i = 15; i >= 0; i--) if (c[i] != 9'd0) pos.push_back(i);
        m_tc   = pos.size();
        m_t1   = 0;
        t1_run = 1'b1;
        m_tz   = (m_tc == 0) ? 0 : pos[0] + 1 - m_tc;
        for (int k = 0; k < m_tc; k++) begin
            s.level = c[pos[k]];
            if (k == m_tc - 1) s.run = 4'(pos[k]);
            else               s.run = 4'(pos[k] - pos[k+1] - 1);
            t1_run = t1_run && (k < 3) && (c[pos[k]] == 9'h001 || c[pos[k]] == 9'h1FF);
            s.t1   = t1_run;
            if (t1_run) m_t1++;
            s.last = (k == m_tc - 1);
            if (push) sbq.push_back(s);
        end
    endfunction

    task automatic kick_and_check(input logic [15:0][8:0] c, input int etc, input int et1,
                                  input int etz, input int id);
        int cnt;
        bit seen;
        int d_tc, d_t1, d_tz;
        for (int i = 0; i < 16; i++) mem[i] = c[i];
        model_block(c, 1'b1, d_tc, d_t1, d_tz);
        @(posedge clk); #1 start = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            if (stats_valid) seen = 1'b1;
            else begin
                cnt++;
                @(posedge clk); #1 start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!seen || cnt != 18) begin
            n_fail++;
            $display("FAIL stats_latency[%0d]: got %0d cycles (seen=%0b), want 18", id, cnt, seen);
        end
        n_checks++;
        if (!seen || int'(total_coeff) != etc || int'(trailing_ones) != et1 || int'(total_zeros) != etz) begin
            n_fail++;
            $display("FAIL stats[%0d]: got tc=%0d t1=%0d tz=%0d, want tc=%0d t1=%0d tz=%0d",
                     id, total_coeff, trailing_ones, total_zeros, etc, et1, etz);
        end
    endtask

    task automatic wait_idle(input int id);
        int cnt = 0;
        while (busy && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL idle_timeout[%0d]: busy still %0b after %0d cycles, want 0", id, busy, cnt);
        end
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sym_count[%0d]: %0d expected symbols never emitted, want 0", id, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic check_quiet(input int cycles, input int id);
        bit woke = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy || stats_valid || sym_valid || rd_en) woke = 1'b1;
        end
        n_checks++;
        if (woke) begin
            n_fail++;
            $display("FAIL quiet[%0d]: got activity while idle, want none", id);
        end
    endtask

    initial begin
        logic [15:0][8:0] c;
        logic [14:0]      snap;
        int               r_tc, r_t1, r_tz, cnt, r;

        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][8:0] c;
        logic [14:0]      snap;
        int               r_tc, r_t1, r_tz, cnt, r;

        rst = 1'b0; start = 1'b0; sym_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 9'd0;

        for (int v = 0; v < NV; v++) vecs[v].coef = '0;
        vecs[0].tc = 0;  vecs[0].t1 = 0; vecs[0].tz = 0;
        vecs[1].coef[1] = 9'd3;   vecs[1].coef[2] = 9'h1FF; vecs[1].coef[5] = 9'h1FF;
        vecs[1].coef[6] = 9'd1;   vecs[1].coef[8] = 9'd1;
        vecs[1].tc = 5;  vecs[1].t1 = 3; vecs[1].tz = 4;
        for (int i = 0; i < 16; i++) vecs[2].coef[i] = 9'd2;
        vecs[2].tc = 16; vecs[2].t1 = 0; vecs[2].tz = 0;
        vecs[3].coef[0] = 9'h100; vecs[3].coef[15] = 9'h0FF;
        vecs[3].tc = 2;  vecs[3].t1 = 0; vecs[3].tz = 14;
        vecs[4].coef[0] = 9'd1;   vecs[4].coef[1] = 9'h1FF; vecs[4].coef[2] = 9'd1;
        vecs[4].coef[3] = 9'h1FF;
        vecs[4].tc = 4;  vecs[4].t1 = 3; vecs[4].tz = 0;
        vecs[5].coef[15] = 9'd1;
        vecs[5].tc = 1;  vecs[5].t1 = 1; vecs[5].tz = 15;
        vecs[6].coef[3] = 9'h1FF; vecs[6].coef[10] = 9'd2; vecs[6].coef[12] = 9'd1;
        vecs[6].tc = 3;  vecs[6].t1 = 1; vecs[6].tz = 10;

        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, rd_en, rd_addr, stats_valid, total_coeff, trailing_ones, total_zeros,
             sym_valid, sym_level, sym_run, sym_t1, sym_last} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_state: got nonzero outputs busy=%0b rd_en=%0b sym_valid=%0b, want all 0",
                     busy, rd_en, sym_valid);
        end
        rst = 1'b1;

        for (int v = 0; v < NV; v++) begin
            kick_and_check(vecs[v].coef, vecs[v].tc, vecs[v].t1, vecs[v].tz, v);
            if (vecs[v].tc == 0) begin
                @(negedge clk);
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zero_busy_drop[%0d]: got busy=%0b, want 0", v, busy);
                end
            end
            wait_idle(v);
        end

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(0, 9);
                if (r < 5)      c[i] = 9'd0;
                else if (r < 8) c[i] = (r == 6) ? 9'h1FF : 9'h001;
                else            c[i] = 9'($urandom_range(1, 511));
            end
            model_block(c, 1'b0, r_tc, r_t1, r_tz);
            kick_and_check(c, r_tc, r_t1, r_tz, 10 + n);
            wait_idle(10 + n);
        end

        // Backpressure with stalls, a start during EMIT, and a start on the last handshake.
        sym_ready = 1'b0;
        kick_and_check(vecs[1].coef, 5, 3, 4, 100);
        cnt = 0;
        while (!sym_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        snap = {sym_level, sym_run, sym_t1, sym_last};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (!sym_valid || {sym_level, sym_run, sym_t1, sym_last} !== snap) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%0b sym=%h, want valid=1 sym=%h",
                         i, sym_valid, {sym_level, sym_run, sym_t1, sym_last}, snap);
            end
        end
        @(posedge clk); #1 sym_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 sym_ready = 1'b0; start = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (!(sym_valid && sym_last) && cnt < 20) begin
            @(posedge clk); #1 sym_ready = 1'b1;
            @(posedge clk); #1 sym_ready = 1'b0;
            @(negedge clk);
            cnt++;
        end
        @(posedge clk); #1 sym_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(100);
        check_quiet(25, 100);

        // Reset in the seventh READ cycle aborts the block.
        for (int i = 0; i < 16; i++) mem[i] = vecs[2].coef[i];
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, rd_en, rd_addr, stats_valid, total_coeff, trailing_ones, total_zeros,
             sym_valid, sym_level, sym_run, sym_t1, sym_last} !== 35'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%0b rd_en=%0b rd_addr=%0d tc=%0d, want all 0",
                     busy, rd_en, rd_addr, total_coeff);
        end
        @(posedge clk); #1 rst = 1'b1;
        check_quiet(25, 200);
        kick_and_check(vecs[1].coef, 5, 3, 4, 201);
        wait_idle(201);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
